// File: rtl/int_sync_crossing_sink.sv
// Interrupt crossing sink: per-line synchronizer, optional glitch filter, sticky rising-edge pending flags.
// Build option: define INT_SYNC_CROSSING_SINK_FILTER_EN to insert the glitch filter ahead of auto_out.
module int_sync_crossing_sink #(
   parameter int WIDTH         = 4,
   parameter int SYNC_STAGES   = 3,
   parameter int FILTER_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] auto_in_sync,
   output logic [WIDTH-1:0] auto_out,
   output logic [WIDTH-1:0] pend,
   input  logic [WIDTH-1:0] clr
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("int_sync_crossing_sink: WIDTH must be 1..32");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("int_sync_crossing_sink: SYNC_STAGES must be 2..4");
   end
   if (FILTER_CYCLES < 2 || FILTER_CYCLES > 15) begin : g_bad_filter
      $error("int_sync_crossing_sink: FILTER_CYCLES must be 2..15");
   end

   // sync_q[0] is the first flop after the asynchronous boundary
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync_out;
   logic [WIDTH-1:0]                  prev;
   logic [WIDTH-1:0]                  rise;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], auto_in_sync};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef INT_SYNC_CROSSING_SINK_FILTER_EN
   // A line only changes once the synchronized value has disagreed with auto_out for FILTER_CYCLES edges
   logic [WIDTH-1:0][3:0] cnt;
   logic [WIDTH-1:0]      filt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         filt_q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == filt_q[i]) begin
               cnt[i] <= 4'd0;
            end else if (cnt[i] == 4'(FILTER_CYCLES - 1)) begin
               filt_q[i] <= sync_out[i];
               cnt[i]    <= 4'd0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   assign auto_out = filt_q;
`else
   assign auto_out = sync_out;
`endif

   assign rise = auto_out & ~prev;

   // set takes priority over a same-cycle clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev <= '0;
         pend <= '0;
      end else begin
         prev <= auto_out;
         pend <= (pend & ~clr) | rise;
      end
   end

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
// Directed self-checking bench for int_sync_crossing_sink (default parameters).
// Latency expectations follow INT_SYNC_CROSSING_SINK_FILTER_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_int_sync_crossing_sink;

`ifdef INT_SYNC_CROSSING_SINK_FILTER_EN
   localparam int LAT = 3 + 4;
`else
   localparam int LAT = 3;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] auto_in_sync;
   logic [3:0] auto_out;
   logic [3:0] pend;
   logic [3:0] clr;

   int n_checks = 0;
   int n_errors = 0;

   int_sync_crossing_sink dut (
      .clock        (clock),
      .reset        (reset),
      .auto_in_sync (auto_in_sync),
      .auto_out     (auto_out),
      .pend         (pend),
      .clr          (clr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   initial begin
      reset        = 1'b0;
      auto_in_sync = 4'b0000;
      clr          = 4'b0000;
      @(negedge clock);
      check("reset_out", auto_out, 4'b0000);
      check("reset_pend", pend, 4'b0000);
      tick(2);
      reset = 1'b1;
      tick(6);
      check("idle_out", auto_out, 4'b0000);
      check("idle_pend", pend, 4'b0000);

      // single rising edge on bit 0
      auto_in_sync = 4'b0001;
      for (int c = 1; c < LAT; c++) begin
         tick();
         check("lat_early_out", auto_out, 4'b0000);
      end
      tick();
      check("lat_out", auto_out, 4'b0001);
      check("lat_pend_not_yet", pend, 4'b0000);
      tick();
      check("lat_pend", pend, 4'b0001);

      // clear of an idle line is ignored, then a real clear
      clr = 4'b0010;
      tick();
      check("clr_idle", pend, 4'b0001);
      clr = 4'b0001;
      tick();
      clr = 4'b0000;
      check("clr_bit0", pend, 4'b0000);
      tick(2);
      check("clr_no_reset_from_level", pend, 4'b0000);

      // falling edge does not set pend
      auto_in_sync = 4'b0000;
      tick(LAT + 3);
      check("fall_out", auto_out, 4'b0000);
      check("fall_pend", pend, 4'b0000);

      // bit 2: set pend, drop, re-raise with clear landing on the set cycle
      auto_in_sync = 4'b0100;
      tick(LAT + 1);
      check("b2_first_pend", pend, 4'b0100);
      auto_in_sync = 4'b0000;
      tick(LAT + 1);
      check("b2_low_out", auto_out, 4'b0000);
      check("b2_low_pend_held", pend, 4'b0100);
      auto_in_sync = 4'b0100;
      tick(LAT);
      check("b2_rise_out", auto_out, 4'b0100);
      clr = 4'b0100;
      tick();
      clr = 4'b0000;
      check("set_beats_clr", pend, 4'b0100);

      // independent lines, pattern 1010; bit 2 drops, pend[2] stays
      auto_in_sync = 4'b1010;
      tick(LAT);
      check("pat_out", auto_out, 4'b1010);
      tick();
      check("pat_pend", pend, 4'b1110);

      // clear everything, then bring all lines high
      auto_in_sync = 4'b0000;
      clr = 4'b1111;
      tick(LAT + 2);
      clr = 4'b0000;
      check("all_cleared", pend, 4'b0000);
      auto_in_sync = 4'b1111;
      tick(LAT + 1);
      check("all_out", auto_out, 4'b1111);
      check("all_pend", pend, 4'b1111);

      // asynchronous reset in the middle of the low phase
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_out", auto_out, 4'b0000);
      check("async_rst_pend", pend, 4'b0000);
      auto_in_sync = 4'b0000;
      @(negedge clock);
      reset = 1'b1;
      tick(LAT + 3);
      check("post_rst_out", auto_out, 4'b0000);
      check("post_rst_pend", pend, 4'b0000);

      // in-flight edge discarded by reset
      auto_in_sync = 4'b0010;
      tick();
      reset = 1'b0;
      auto_in_sync = 4'b0000;
      tick();
      reset = 1'b1;
      tick(LAT + 3);
      check("inflight_out", auto_out, 4'b0000);
      check("inflight_pend", pend, 4'b0000);

      // input already high across reset release
      reset = 1'b0;
      auto_in_sync = 4'b0001;
      tick(2);
      reset = 1'b1;
      for (int c = 1; c < LAT; c++) begin
         tick();
         check("rel_early_out", auto_out, 4'b0000);
      end
      tick();
      check("rel_out", auto_out, 4'b0001);
      check("rel_pend_not_yet", pend, 4'b0000);
      tick();
      check("rel_pend", pend, 4'b0001);

`ifdef INT_SYNC_CROSSING_SINK_FILTER_EN
      // short pulse on bit 3 is filtered away
      auto_in_sync = 4'b1001;
      tick(2);
      auto_in_sync = 4'b0001;
      for (int c = 0; c < 12; c++) begin
         tick();
         check("glitch_out", auto_out, 4'b0001);
         check("glitch_pend", pend, 4'b0001);
      end
      auto_in_sync = 4'b1001;
      tick(6);
      check("filt_early_out", auto_out, 4'b0001);
      tick();
      check("filt_out", auto_out, 4'b1001);
      tick();
      check("filt_pend", pend, 4'b1001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/int_sync_crossing_sink.md
INT_SYNC_CROSSING_SINK -- requirements
Module: int_sync_crossing_sink

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, giving the number of interrupt lines (legal 1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 3, giving the synchronizer depth in flops (legal 2..4).
REQ-003 SHALL provide parameter FILTER_CYCLES, default 4, giving the glitch-filter stability window in cycles (legal 2..15; used only when filtering is compiled in).
REQ-004 SHALL have port clock, input, 1 bit: the single sink-domain clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port auto_in_sync, input, WIDTH bits: interrupt levels from the source domain, asynchronous to clock.
REQ-007 SHALL have port auto_out, output, WIDTH bits: synchronized (and optionally filtered) interrupt levels.
REQ-008 SHALL have port pend, output, WIDTH bits: per-line sticky rising-edge flags.
REQ-009 SHALL have port clr, input, WIDTH bits: per-line pending clear, synchronous to clock, sampled each cycle.

Function
REQ-010 SHALL pass each auto_in_sync bit through its own chain of SYNC_STAGES flops, with no logic between stages.
REQ-011 SHALL, with filtering compiled out, drive auto_out from the last synchronizer stage: an input change stable across edges appears exactly SYNC_STAGES rising edges later.
REQ-012 SHALL treat lines independently; no bit of any output depends on another line's input.
REQ-013 SHALL keep a registered copy of the previous auto_out value per line (prev).
REQ-014 SHALL set pend[i] in the cycle after auto_out[i] goes from 0 to 1, i.e. one cycle after the rising edge appears on auto_out[i].
REQ-015 SHALL clear pend[i] on the cycle after clr[i]=1 sampled while pend[i]=1.
REQ-016 SHALL let set win when a set event and clr[i] occur in the same cycle: pend[i] stays 1.
REQ-017 SHALL ignore clr[i] when pend[i]=0; a clear does not block a later set.
REQ-018 SHALL not set pend[i] on a falling edge; pend[i] is not affected by auto_out[i] returning to 0.
REQ-019 SHALL hold pend[i]=1 across repeated rising edges: no count and no overflow.

Reset
REQ-020 SHALL, while reset=0, force all synchronizer flops, prev, pend and filter state to 0 asynchronously, so that auto_out=0 and pend=0.
REQ-021 SHALL require the reset deassertion to be synchronous to clock, supplied by the reset infrastructure.
REQ-022 SHALL not produce a spurious pend on the first cycles after reset when auto_in_sync=0.
REQ-023 SHALL, if auto_in_sync[i]=1 at reset release, assert auto_out[i] after the normal latency and then set pend[i] (a 0-to-1 transition from reset state).
REQ-024 SHALL, on reset asserted mid-operation, discard in-flight synchronizer and filter state with no residual effect after release.

Configuration
REQ-025 SHALL compile a per-line glitch filter between the last synchronizer stage and auto_out when INT_SYNC_CROSSING_SINK_FILTER_EN is defined.
REQ-026 SHALL, with the filter compiled in, keep a 4-bit counter per line: cleared when the sync output equals auto_out; incremented when they differ; when the count reaches FILTER_CYCLES-1 with the values still differing, auto_out takes the sync value and the count clears.
REQ-027 SHALL, with the filter compiled in, give a total latency of SYNC_STAGES+FILTER_CYCLES cycles for a stable change, and suppress any sync-output pulse shorter than FILTER_CYCLES cycles.
REQ-028 SHALL, with INT_SYNC_CROSSING_SINK_FILTER_EN undefined, contain no counter logic and behave per REQ-011.

Verification
REQ-029 SHALL cover, with defaults and no filter: auto_in_sync 0000->0001 held -> auto_out[0]=1 exactly 3 edges later, then pend[0]=1 one cycle after that; other bits stay 0.
REQ-030 SHALL cover: pend=0001, clr=0001 for 1 cycle -> pend=0000 the next cycle; clr=0010 while pend[1]=0 -> no change.
REQ-031 SHALL cover: a new rising edge reaches pend[2] in the same cycle clr[2]=1 -> pend[2] remains 1.
REQ-032 SHALL cover: reset=0 asserted mid-cycle with auto_out=1111 and pend=1111 -> both read 0000 immediately, without a clock edge; after release with inputs 0 -> they stay 0000.
REQ-033 SHALL cover, with the filter enabled: a 2-cycle pulse on bit 3 -> auto_out[3] and pend[3] never change; a held input -> auto_out[3]=1 after 7 cycles.
REQ-034 SHALL cover: auto_in_sync=0001 held through reset release -> auto_out[0]=1 after 3 cycles and pend[0]=1 one cycle later.
